// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory sequencer: byte-lane steering for stores, latency-counted loads with
// lane extraction and sign/zero extension, and rejection of misaligned or illegal accesses.
//   state   | meaning
//   IDLE    | accept requests; stores complete here, loads are issued
//   RD_WAIT | load in flight, counting BRAM read latency
//   RD_DONE | result registered, rdata_valid high, pipeline released
module dmem_access_ctrl #(
    parameter int MEM_AW   = 12,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic [3:0]        mem_write,
    input  logic [1:0]        read_size,
    input  logic              read_signed,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign_err,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [MEM_AW-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    localparam logic [1:0] LAT = 2'(READ_LAT);

    state_t      state_q;
    logic [1:0]  lat_cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] rdata_q;
    logic        rdata_valid_q;

    logic        is_store, mask_bad, misaligned, bad, access;
    logic        do_store, do_load;
    logic [1:0]  st_size, acc_size;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext_d;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr[31:MEM_AW+2];

    always_comb begin
        is_store = (mem_write != 4'b0000);
        mask_bad = 1'b0;
        case (mem_write)
            4'b0001: st_size = 2'd0;
            4'b0011: st_size = 2'd1;
            4'b1111: st_size = 2'd2;
            default: begin
                st_size  = 2'd2;
                mask_bad = is_store;
            end
        endcase
        acc_size   = is_store ? st_size : ((read_size == 2'd3) ? 2'd2 : read_size);
        misaligned = ((acc_size == 2'd1) && addr[0]) ||
                     ((acc_size == 2'd2) && (addr[1:0] != 2'b00));
        bad        = (mem_read && is_store) || mask_bad || misaligned;
        // Outputs stay quiet while reset is asserted and outside IDLE.
        access     = rst_n && req_valid && (state_q == IDLE) && (mem_read || is_store);
        do_store   = access && !bad && is_store;
        do_load    = access && !bad && mem_read;

        misalign_err = access && bad;
        bram_en      = do_store || do_load;
        bram_we      = do_store ? 4'(mem_write << addr[1:0]) : 4'b0000;
        stall        = do_load || (rst_n && (state_q == RD_WAIT));
        case (st_size)
            2'd0:    bram_wdata = {4{wdata[7:0]}};
            2'd1:    bram_wdata = {2{wdata[15:0]}};
            default: bram_wdata = wdata;
        endcase
    end

    assign bram_addr = addr[MEM_AW+1:2];

    always_comb begin
        lane_b = bram_rdata[{off_q, 3'b000} +: 8];
        lane_h = bram_rdata[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    ext_d = {{24{sgn_q & lane_b[7]}}, lane_b};
            2'd1:    ext_d = {{16{sgn_q & lane_h[15]}}, lane_h};
            default: ext_d = bram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            lat_cnt_q     <= 2'd0;
            off_q         <= 2'd0;
            size_q        <= 2'd0;
            sgn_q         <= 1'b0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (do_load) begin
                        off_q     <= addr[1:0];
                        size_q    <= acc_size;
                        sgn_q     <= read_signed;
                        lat_cnt_q <= 2'd1;
                        state_q   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    lat_cnt_q <= lat_cnt_q + 2'd1;
                    if (lat_cnt_q == LAT) begin
                        rdata_q       <= ext_d;
                        rdata_valid_q <= 1'b1;
                        state_q       <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    lat_cnt_q <= 2'd0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule
